// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - select encoding and port count shared by the 1:4 stream demux
package demux_pkg;

  localparam int NUM_PORTS = 4;

  localparam logic [1:0] SEL_A = 2'b00;
  localparam logic [1:0] SEL_B = 2'b01;
  localparam logic [1:0] SEL_C = 2'b10;
  localparam logic [1:0] SEL_D = 2'b11;

  // one-hot destination for a 2-bit select: bit0=a .. bit3=d
  function automatic logic [NUM_PORTS-1:0] sel_decode(input logic [1:0] sel);
    logic [NUM_PORTS-1:0] oh;
    case (sel)
      SEL_A:   oh = 4'b0001;
      SEL_B:   oh = 4'b0010;
      SEL_C:   oh = 4'b0100;
      default: oh = 4'b1000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/demux1to4_stream_if.sv
// rtl/demux1to4_stream_if.sv - stream bus of the 1:4 demux; in_bcast exists only with DEMUX_BROADCAST_EN
interface demux1to4_stream_if #(parameter int WIDTH = 8);

  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_select;
  logic             in_valid;
  logic             in_ready;
`ifdef DEMUX_BROADCAST_EN
  logic             in_bcast;
`endif
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;

  modport master (
    output in_data, in_select, in_valid, out_ready,
`ifdef DEMUX_BROADCAST_EN
    output in_bcast,
`endif
    input  in_ready, a, b, c, d, out_valid
  );

  modport slave (
    input  in_data, in_select, in_valid, out_ready,
`ifdef DEMUX_BROADCAST_EN
    input  in_bcast,
`endif
    output in_ready, a, b, c, d, out_valid
  );

endinterface

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - small per-port FIFO, registered storage, no fall-through
module stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW-1:0]    last_idx;
  logic             do_push;
  logic             do_pop;

  // extra pointer bit distinguishes full from empty when the indices match
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;

  // while empty, show the entry just popped so the output holds its last value
  assign last_idx = rd_ptr[AW-1:0] - AW'(1);
  assign dout     = empty ? mem[last_idx] : mem[rd_ptr[AW-1:0]];

  // storage and pointer update; reset clears contents so outputs start at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/demux1to4_stream.sv
// rtl/demux1to4_stream.sv - 1:4 stream demux with per-port FIFOs and pop counters; DEMUX_BROADCAST_EN adds broadcast
module demux1to4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  demux1to4_stream_if.slave   bus,
  output logic [CNT_W-1:0]    cnt_a,
  output logic [CNT_W-1:0]    cnt_b,
  output logic [CNT_W-1:0]    cnt_c,
  output logic [CNT_W-1:0]    cnt_d
);

  logic [NUM_PORTS-1:0] sel_oh;
  logic [NUM_PORTS-1:0] dest;
  logic [NUM_PORTS-1:0] full;
  logic [NUM_PORTS-1:0] empty;
  logic [NUM_PORTS-1:0] push_vec;
  logic [NUM_PORTS-1:0] pop_vec;
  logic [WIDTH-1:0]     dout [NUM_PORTS];
  logic [CNT_W-1:0]     cnt  [NUM_PORTS];
  logic                 accept;

  assign sel_oh = sel_decode(bus.in_select);

  // ready looks only at destination fullness, never at in_valid; a full
  // FIFO refuses even while it is being popped (no pass-through)
`ifdef DEMUX_BROADCAST_EN
  assign bus.in_ready = bus.in_bcast ? ~|full : ~full[bus.in_select];
  assign dest         = bus.in_bcast ? {NUM_PORTS{1'b1}} : sel_oh;
`else
  assign bus.in_ready = ~full[bus.in_select];
  assign dest         = sel_oh;
`endif

  assign accept        = bus.in_valid & bus.in_ready;
  assign push_vec      = dest & {NUM_PORTS{accept}};
  assign pop_vec       = ~empty & bus.out_ready;
  assign bus.out_valid = ~empty;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push_vec[k]),
      .pop   (pop_vec[k]),
      .din   (bus.in_data),
      .dout  (dout[k]),
      .full  (full[k]),
      .empty (empty[k])
    );
  end

  assign bus.a = dout[0];
  assign bus.b = dout[1];
  assign bus.c = dout[2];
  assign bus.d = dout[3];

  // per-port pop counters, free-running with natural wrap
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rst)             cnt[k] <= '0;
      else if (pop_vec[k]) cnt[k] <= cnt[k] + CNT_W'(1);
    end
  end

  assign cnt_a = cnt[0];
  assign cnt_b = cnt[1];
  assign cnt_c = cnt[2];
  assign cnt_d = cnt[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// tb/tb_demux1to4_stream.sv - scoreboard bench for demux1to4_stream; covers broadcast when DEMUX_BROADCAST_EN is defined
module tb_demux1to4_stream;

  logic       clk;
  logic       rst;
  logic [7:0] cnt_a, cnt_b, cnt_c, cnt_d;
  int         n_checks;
  int         n_pass;
  int         w;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] q2[$];
  logic [7:0] q3[$];

  demux1to4_stream_if #(.WIDTH(8)) bus();

  demux1to4_stream #(.WIDTH(8), .DEPTH(2), .CNT_W(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .cnt_a (cnt_a),
    .cnt_b (cnt_b),
    .cnt_c (cnt_c),
    .cnt_d (cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic void push_exp(input int k, input logic [7:0] v);
    case (k)
      0: q0.push_back(v);
      1: q1.push_back(v);
      2: q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endfunction

  function automatic logic [7:0] port_data(input int k);
    case (k)
      0: return bus.a;
      1: return bus.b;
      2: return bus.c;
      default: return bus.d;
    endcase
  endfunction

  task automatic pop_exp(input int k, output bit ok, output logic [7:0] v);
    ok = 1'b1;
    v  = 8'h00;
    case (k)
      0: if (q0.size() > 0) v = q0.pop_front(); else ok = 1'b0;
      1: if (q1.size() > 0) v = q1.pop_front(); else ok = 1'b0;
      2: if (q2.size() > 0) v = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) v = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  // monitor: every handshaken output beat is checked against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        if (bus.out_valid[k] && bus.out_ready[k]) begin
          bit         ok;
          logic [7:0] v;
          pop_exp(k, ok, v);
          if (!ok) chk($sformatf("unexpected_beat_port%0d", k), 32'(port_data(k)), 32'hFFFF_FFFF);
          else     chk($sformatf("data_port%0d", k), 32'(port_data(k)), 32'(v));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // offer one beat at posedge+1; return at posedge+1 after it was accepted
  task automatic send(input logic [7:0] v, input logic [1:0] s, output int waited);
    waited = 0;
    bus.in_data   = v;
    bus.in_select = s;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 40) begin
      waited++;
      @(negedge clk);
    end
    if (bus.in_ready) begin
      @(posedge clk);
      push_exp(int'(s), v);
    end else begin
      chk("send_ready_timeout", 32'(bus.in_ready), 32'd1);
    end
    #1;
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst = 1'b1;
    bus.in_data   = 8'h00;
    bus.in_select = 2'b00;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'h0;
`ifdef DEMUX_BROADCAST_EN
    bus.in_bcast  = 1'b0;
`endif
    cyc(2);
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("reset_out_valid", 32'(bus.out_valid), 32'h0);
    chk("reset_a", 32'(bus.a), 32'h0);
    chk("reset_b", 32'(bus.b), 32'h0);
    chk("reset_c", 32'(bus.c), 32'h0);
    chk("reset_d", 32'(bus.d), 32'h0);
    chk("reset_cnt_a", 32'(cnt_a), 32'h0);
    chk("reset_cnt_d", 32'(cnt_d), 32'h0);
    cyc(1);

    // routing
    bus.out_ready = 4'hF;
    send(8'hAA, 2'b00, w); @(negedge clk); chk("route_valid_a", 32'(bus.out_valid[0]), 32'd1); cyc(1);
    send(8'hBB, 2'b01, w); @(negedge clk); chk("route_valid_b", 32'(bus.out_valid[1]), 32'd1); cyc(1);
    send(8'hCC, 2'b10, w); @(negedge clk); chk("route_valid_c", 32'(bus.out_valid[2]), 32'd1); cyc(1);
    send(8'hDD, 2'b11, w); @(negedge clk); chk("route_valid_d", 32'(bus.out_valid[3]), 32'd1); cyc(2);
    @(negedge clk);
    chk("route_cnt_a", 32'(cnt_a), 32'd1);
    chk("route_cnt_b", 32'(cnt_b), 32'd1);
    chk("route_cnt_c", 32'(cnt_c), 32'd1);
    chk("route_cnt_d", 32'(cnt_d), 32'd1);
    cyc(1);

    // backpressure on a, b stays isolated
    bus.out_ready = 4'b1110;
    send(8'h11, 2'b00, w); chk("bp_push1_wait", 32'(w), 32'd0);
    send(8'h22, 2'b00, w); chk("bp_push2_wait", 32'(w), 32'd0);
    bus.in_data = 8'h99; bus.in_select = 2'b00; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bp_full_a_ready", 32'(bus.in_ready), 32'd0);
    chk("bp_a_valid", 32'(bus.out_valid[0]), 32'd1);
    cyc(1);
    bus.in_valid = 1'b0;
    send(8'h33, 2'b01, w); chk("iso_b_wait", 32'(w), 32'd0);
    @(negedge clk); chk("iso_b_valid", 32'(bus.out_valid[1]), 32'd1);
    cyc(1);
    bus.out_ready = 4'hF;
    cyc(4);
    @(negedge clk);
    chk("bp_cnt_a", 32'(cnt_a), 32'd3);
    chk("bp_cnt_b", 32'(cnt_b), 32'd2);
    cyc(1);

    // simultaneous push and pop on c with one entry held
    bus.out_ready = 4'h0;
    send(8'h55, 2'b10, w);
    bus.in_data = 8'h44; bus.in_select = 2'b10; bus.in_valid = 1'b1;
    bus.out_ready = 4'b0100;
    @(negedge clk);
    chk("pp_c_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    push_exp(2, 8'h44);
    #1;
    bus.in_valid = 1'b0; bus.out_ready = 4'h0;
    @(negedge clk);
    chk("pp_c_valid", 32'(bus.out_valid[2]), 32'd1);
    chk("pp_c_head", 32'(bus.c), 32'h44);
    cyc(1);
    bus.out_ready = 4'b0100;
    cyc(1);
    bus.out_ready = 4'h0;
    @(negedge clk);
    chk("pp_c_occupancy_one", 32'(bus.out_valid[2]), 32'd0);
    cyc(1);

    // full d: no pass-through while popping
    send(8'hD1, 2'b11, w);
    send(8'hD2, 2'b11, w);
    bus.in_data = 8'hD3; bus.in_select = 2'b11; bus.in_valid = 1'b1;
    bus.out_ready = 4'b1000;
    @(negedge clk);
    chk("full_d_ready_pop_cycle", 32'(bus.in_ready), 32'd0);
    cyc(1);
    bus.out_ready = 4'h0;
    @(negedge clk);
    chk("full_d_ready_next", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    push_exp(3, 8'hD3);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 4'hF;
    cyc(4);
    @(negedge clk);
    chk("full_cnt_c", 32'(cnt_c), 32'd3);
    chk("full_cnt_d", 32'(cnt_d), 32'd4);
    cyc(1);

    // reset with entries buffered and a beat offered
    bus.out_ready = 4'h0;
    send(8'hE1, 2'b01, w);
    send(8'hE2, 2'b10, w);
    rst = 1'b1;
    bus.in_data = 8'hE3; bus.in_select = 2'b00; bus.in_valid = 1'b1;
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    cyc(1);
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_mid_a", 32'(bus.a), 32'h0);
    chk("rst_mid_cnt_a", 32'(cnt_a), 32'h0);
    chk("rst_mid_cnt_b", 32'(cnt_b), 32'h0);
    chk("rst_mid_cnt_c", 32'(cnt_c), 32'h0);
    chk("rst_mid_cnt_d", 32'(cnt_d), 32'h0);
    cyc(1);

    // counter wrap on a
    bus.out_ready = 4'hF;
    for (int i = 0; i < 255; i++) send(8'(i), 2'b00, w);
    cyc(3);
    @(negedge clk);
    chk("wrap_cnt_a_ff", 32'(cnt_a), 32'hFF);
    cyc(1);
    send(8'hFF, 2'b00, w);
    cyc(3);
    @(negedge clk);
    chk("wrap_cnt_a_00", 32'(cnt_a), 32'h00);
    cyc(1);

`ifdef DEMUX_BROADCAST_EN
    // broadcast to all ports, then refusal when any FIFO is full
    bus.out_ready = 4'h0;
    bus.in_bcast = 1'b1; bus.in_data = 8'h5A; bus.in_select = 2'b01; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("bc_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < 4; k++) push_exp(k, 8'h5A);
    #1;
    bus.in_data = 8'h5B;
    @(negedge clk);
    chk("bc_out_valid", 32'(bus.out_valid), 32'hF);
    chk("bc_a", 32'(bus.a), 32'h5A);
    chk("bc_b", 32'(bus.b), 32'h5A);
    chk("bc_c", 32'(bus.c), 32'h5A);
    chk("bc_d", 32'(bus.d), 32'h5A);
    @(posedge clk);
    for (int k = 0; k < 4; k++) push_exp(k, 8'h5B);
    #1;
    bus.in_data = 8'h5C;
    @(negedge clk);
    chk("bc_full_ready", 32'(bus.in_ready), 32'd0);
    cyc(1);
    bus.out_ready = 4'b0001;
    @(negedge clk);
    chk("bc_partial_full_ready", 32'(bus.in_ready), 32'd0);
    cyc(1);
    bus.in_valid = 1'b0; bus.in_bcast = 1'b0;
    bus.out_ready = 4'hF;
    cyc(6);
`endif

    // every expected beat must have been delivered
    bus.out_ready = 4'hF;
    cyc(4);
    chk("scoreboard_drained", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux1to4_stream.md
Name: demux1to4_stream

Overview:
- 1-to-4 stream demultiplexer: routes each accepted byte from a single input stream to one of four output ports (a, b, c, d), chosen by a 2-bit select sent with the data.
- Each output port has its own small FIFO, so a stalled port does not block traffic bound for the other ports.
- Sits downstream of the existing 4:1 mux datapath and performs the reverse fan-out, with valid/ready handshakes on every port.

Parameters:
- WIDTH, 8, data width of the input and of each output port.
- DEPTH, 2, entries per output FIFO; power of two, at least 2.
- CNT_W, 8, width of the per-port transfer counters.

Ports:
- clk  input  1  single clock; every register updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  input payload.
- in_select  input  2  destination port: 00=a, 01=b, 10=c, 11=d.
- in_valid  input  1  producer holds a valid beat.
- in_ready  output  1  block accepts the beat this cycle.
- a, b, c, d  output  WIDTH each  head-of-FIFO data for each port.
- out_valid  output  4  bit0=a … bit3=d; port FIFO non-empty.
- out_ready  input  4  consumer accepts the head entry, per port.
- cnt_a, cnt_b, cnt_c, cnt_d  output  CNT_W each  count of beats popped from each port.

Behaviour:
- Reset (rst=1 at a clk edge): all FIFOs empty; out_valid=0; a/b/c/d=0; all counters=0. A reset asserted mid-transfer discards buffered data, and nothing is accepted in that cycle.
- in_ready is combinational: it is high when the FIFO selected by in_select is not full. It must not depend on in_valid.
- Accept (push) occurs when in_valid & in_ready. The beat enters FIFO[in_select] at the edge.
- Latency: an accepted beat appears on its port with out_valid high the next cycle. There is no combinational fall-through.
- Pop on port k occurs when out_valid[k] & out_ready[k]. The next entry, if any, appears the following cycle.
- A push and a pop on the same port in the same cycle, with the FIFO non-empty and not full, both take effect; occupancy is unchanged.
- Full FIFO: in_ready stays low for that port even if it is being popped this cycle. There is no pass-through when full.
- Empty FIFO: out_valid low; the data output holds its last value. Verification checks data only while out_valid is high.
- Producer rule: while in_valid is high and in_ready is low, in_data and in_select must stay stable. The block is not required to tolerate changes.
- Pointers wrap modulo DEPTH. Occupancy is tracked with an extra bit, so full and empty are unambiguous.
- Counters: cnt_k increments on each pop of port k and wraps from 2^CNT_W−1 to 0 without saturating.
- Pops on all four ports and a push on a fifth path can all occur in the same cycle; ports are fully independent.

Optional Feature:
- Macro DEMUX_BROADCAST_EN.
- Defined:
  - Adds input port in_bcast (1 bit).
  - When in_bcast=1, in_ready = all four FIFOs not full, and an accepted beat is pushed into all four FIFOs in the same cycle; in_select is ignored.
  - When in_bcast=0, behaviour is identical to the undefined case.
- Undefined: no in_bcast port, and no broadcast logic is synthesised.

Decomposition:
- Package demux_pkg holds:
  - the select encoding constants (SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_D=2'b11);
  - the NUM_PORTS=4 constant.
- One sub-module, stream_fifo (parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty), is instantiated four times.
- Top level holds the select decode, the in_ready mux, the counters and the broadcast logic.

Test Plan:
- Routing: after reset, send 0xAA/00, 0xBB/01, 0xCC/10, 0xDD/11 with out_ready=4'hF → a=0xAA, b=0xBB, c=0xCC, d=0xDD, each valid one cycle after its accept; each cnt_k=1.
- Backpressure and isolation: out_ready[0]=0, push 0x11 then 0x22 to port a → in_ready drops with sel=00 once 2 entries are held. Then 0x33 to port b is accepted immediately and appears on b next cycle. Releasing out_ready[0] yields 0x11 then 0x22 in order.
- Simultaneous push/pop: with port c holding 1 entry, push 0x44 to c while popping c → occupancy stays 1 and the next head is 0x44.
- Full and no pass-through: with port d full, assert out_ready[3]=1 and in_valid with sel=11 in the same cycle → in_ready=0 that cycle and 1 the next.
- Counter wrap and reset: pop 256 beats from port a → cnt_a returns to 0x00. Asserting rst with entries buffered → out_valid=0 and all counters=0 on the next cycle.
- Broadcast (with DEMUX_BROADCAST_EN): in_bcast=1, push 0x5A → all four ports present 0x5A the next cycle. If any FIFO is full, in_ready=0.
